// File: rtl/uart_rx_byte.sv
// -----------------------------------------------------------------------------
// uart_rx_byte
//   Asynchronous serial receiver. Deserialises 8N1 frames (8E1 when the
//   optional parity build is selected) from the board RX pin and hands each
//   good byte to the control path as a one-cycle rxrdy strobe with rxdw.
//   Malformed frames raise frame_err / parity_err pulses instead, and never
//   touch rxdw, so the downstream command decoder cannot act on corruption.
//
//   Build option: define UART_RX_PARITY_EN to receive 8E1 frames (even parity
//   bit after the data bits). Left undefined, the frame is 8N1 and parity_err
//   is tied low.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per bit time (>= 8)
//   HALF_BIT      cycles from detected falling edge to start-bit centre
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   rx          in   serial line, idle high, asynchronous to clk
//   rxrdy       out  one-cycle pulse: rxdw holds a newly received byte
//   rxdw[7:0]   out  last correctly received byte (LSB received first)
//   frame_err   out  one-cycle pulse: stop bit sampled low
//   parity_err  out  one-cycle pulse: parity mismatch (0 in the 8N1 build)
// -----------------------------------------------------------------------------
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 434,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       rxrdy,
  output logic [7:0] rxdw,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  // Terminal counts: the counter reloads to zero at each sample point, so it
  // never runs past CLKS_PER_BIT-1.
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
  localparam logic [2:0] BREAK  = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd5;

  // Even parity over the data byte: the transmitted bit makes the total
  // number of ones (data + parity) even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  logic          rx_meta_r;
  logic          rx_s;
  logic [2:0]    state_r;
  logic [CW-1:0] cnt_r;
  logic [2:0]    bit_cnt_r;
  logic [7:0]    shift_r;
  logic [7:0]    rxdw_r;
  logic          rxrdy_r;
  logic          frame_err_r;
`ifdef UART_RX_PARITY_EN
  logic          par_bad_r;
  logic          parity_err_r;
`endif

  // Two-flop synchroniser; both flops reset high so reset looks like an idle line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_r <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_s      <= rx_meta_r;
    end
  end

  // Receive FSM: baud counting, bit sampling, and registered output pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      bit_cnt_r    <= 3'd0;
      shift_r      <= 8'h00;
      rxdw_r       <= 8'h00;
      rxrdy_r      <= 1'b0;
      frame_err_r  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_r    <= 1'b0;
      parity_err_r <= 1'b0;
`endif
    end else begin
      // Pulses are single-cycle: cleared every cycle unless set below.
      rxrdy_r      <= 1'b0;
      frame_err_r  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_r <= 1'b0;
`endif
      case (state_r)
        IDLE: begin
          cnt_r     <= '0;
          bit_cnt_r <= 3'd0;
          if (!rx_s) begin
            state_r <= START;
          end
        end

        START: begin
          // Re-check the line at the middle of the start bit; a short low
          // glitch is high again by then and is silently dropped.
          if (cnt_r == HALF_LAST) begin
            cnt_r   <= '0;
            state_r <= rx_s ? IDLE : DATA;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end

        DATA: begin
          if (cnt_r == BIT_LAST) begin
            cnt_r   <= '0;
            shift_r <= {rx_s, shift_r[7:1]};
            if (bit_cnt_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_r <= PARITY;
`else
              state_r <= STOP;
`endif
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_r == BIT_LAST) begin
            cnt_r     <= '0;
            par_bad_r <= (rx_s != even_parity(shift_r));
            state_r   <= STOP;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
`endif

        STOP: begin
          // Leaving at mid-stop lets a start bit that follows immediately
          // be caught without an idle gap.
          if (cnt_r == BIT_LAST) begin
            cnt_r <= '0;
            if (rx_s) begin
              state_r <= IDLE;
`ifdef UART_RX_PARITY_EN
              if (par_bad_r) begin
                parity_err_r <= 1'b1;
              end else begin
                rxdw_r  <= shift_r;
                rxrdy_r <= 1'b1;
              end
`else
              rxdw_r  <= shift_r;
              rxrdy_r <= 1'b1;
`endif
            end else begin
              frame_err_r <= 1'b1;
`ifdef UART_RX_PARITY_EN
              parity_err_r <= par_bad_r;
`endif
              state_r <= BREAK;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end

        BREAK: begin
          // A line held low after a bad stop bit must not look like a new start.
          cnt_r <= '0;
          if (rx_s) begin
            state_r <= IDLE;
          end
        end

        default: begin
          cnt_r   <= '0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign rxrdy     = rxrdy_r;
  assign rxdw      = rxdw_r;
  assign frame_err = frame_err_r;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_r;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_byte.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_byte
//   Directed self-checking bench for uart_rx_byte at the default 115200 bps
//   timing (434 clocks per bit). Frames are driven on the falling clock edge;
//   a falling-edge monitor counts output pulses and logs received bytes.
// -----------------------------------------------------------------------------
module tb_uart_rx_byte;

  localparam int C = 434;
  localparam int H = 217;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 2 + H + 10 * C;
`else
  localparam int LAT = 2 + H + 9 * C;
`endif

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       rxrdy;
  logic [7:0] rxdw;
  logic       frame_err;
  logic       parity_err;

  int checks;
  int passes;
  int cyc;
  int start_cyc;
  int rdy_cnt;
  int fe_cnt;
  int pe_cnt;
  int last_rdy_cyc;
  logic [7:0] rdy_log [0:15];

  int rdy0;
  int fe0;
  int pe0;

  uart_rx_byte #(.CLKS_PER_BIT(C), .HALF_BIT(H)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .rxrdy      (rxrdy),
    .rxdw       (rxdw),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts high cycles of each strobe and logs delivered bytes.
  always @(negedge clk) begin
    if (rxrdy) begin
      rdy_log[rdy_cnt % 16] <= rxdw;
      rdy_cnt               <= rdy_cnt + 1;
      last_rdy_cyc          <= cyc;
    end
    if (frame_err)  fe_cnt <= fe_cnt + 1;
    if (parity_err) pe_cnt <= pe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic bit_time(input logic v);
    rx = v;
    repeat (C) @(negedge clk);
  endtask

  // Full frame with correct parity (parity build); caller is at a falling edge.
  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    start_cyc = cyc;
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
`ifdef UART_RX_PARITY_EN
    bit_time(^d);
`endif
    bit_time(stop_b);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic par_b);
    start_cyc = cyc;
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
    bit_time(par_b);
    bit_time(1'b1);
  endtask
`endif

  task automatic snap();
    rdy0 = rdy_cnt;
    fe0  = fe_cnt;
    pe0  = pe_cnt;
  endtask

  initial begin
    checks = 0; passes = 0; cyc = 0; start_cyc = 0;
    rdy_cnt = 0; fe_cnt = 0; pe_cnt = 0; last_rdy_cyc = 0;
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Reset state
    check("reset_rxrdy", {31'd0, rxrdy}, 32'd0);
    check("reset_rxdw", {24'd0, rxdw}, 32'h00);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_parity_err", {31'd0, parity_err}, 32'd0);

    // Single read command byte, with latency
    snap();
    send_frame(8'hF0, 1'b1);
    check("f0_rdy_count", rdy_cnt - rdy0, 32'd1);
    check("f0_rxdw", {24'd0, rxdw}, 32'hF0);
    check("f0_latency", last_rdy_cyc - start_cyc - 1, LAT);
    check("f0_no_frame_err", fe_cnt - fe0, 32'd0);
    check("f0_no_parity_err", pe_cnt - pe0, 32'd0);

    // Back-to-back frames, no idle gap
    snap();
    send_frame(8'h0F, 1'b1);
    send_frame(8'hA5, 1'b1);
    check("b2b_rdy_count", rdy_cnt - rdy0, 32'd2);
    check("b2b_byte0", {24'd0, rdy_log[rdy0 % 16]}, 32'h0F);
    check("b2b_byte1", {24'd0, rdy_log[(rdy0 + 1) % 16]}, 32'hA5);
    check("b2b_no_errs", (fe_cnt - fe0) + (pe_cnt - pe0), 32'd0);
    repeat (2 * C) @(negedge clk);

    // Short low glitch is rejected
    snap();
    rx = 1'b0;
    repeat (100) @(negedge clk);
    rx = 1'b1;
    repeat (2 * C) @(negedge clk);
    check("glitch_no_rdy", rdy_cnt - rdy0, 32'd0);
    check("glitch_no_frame_err", fe_cnt - fe0, 32'd0);
    check("glitch_rxdw_held", {24'd0, rxdw}, 32'hA5);

    // Bad stop bit, line held low three bit times
    snap();
    send_frame(8'h55, 1'b0);
    repeat (2 * C) @(negedge clk);
    rx = 1'b1;
    repeat (2 * C) @(negedge clk);
    check("ferr_count", fe_cnt - fe0, 32'd1);
    check("ferr_no_rdy", rdy_cnt - rdy0, 32'd0);
    check("ferr_rxdw_held", {24'd0, rxdw}, 32'hA5);
    check("ferr_no_parity_err", pe_cnt - pe0, 32'd0);

    // Recovery after the break
    snap();
    send_frame(8'h3C, 1'b1);
    check("after_break_rdy", rdy_cnt - rdy0, 32'd1);
    check("after_break_rxdw", {24'd0, rxdw}, 32'h3C);
    repeat (C) @(negedge clk);

    // Reset mid-frame after four data bits of 0xFF
    bit_time(1'b0);
    rx = 1'b1;
    repeat (4 * C) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_rxdw", {24'd0, rxdw}, 32'h00);
    check("midrst_rxrdy", {31'd0, rxrdy}, 32'd0);
    check("midrst_frame_err", {31'd0, frame_err}, 32'd0);
    snap();
    rst_n = 1'b1;
    repeat (10 * C) @(negedge clk);
    check("postrst_no_pulses", (rdy_cnt - rdy0) + (fe_cnt - fe0) + (pe_cnt - pe0), 32'd0);
    check("postrst_rxdw", {24'd0, rxdw}, 32'h00);

    snap();
    send_frame(8'h81, 1'b1);
    check("post_rst_rdy", rdy_cnt - rdy0, 32'd1);
    check("post_rst_rxdw", {24'd0, rxdw}, 32'h81);
    repeat (C) @(negedge clk);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones, so the even-parity bit must be 1
    snap();
    send_frame_par(8'h07, 1'b0);
    check("par_bad_err", pe_cnt - pe0, 32'd1);
    check("par_bad_no_rdy", rdy_cnt - rdy0, 32'd0);
    check("par_bad_rxdw_held", {24'd0, rxdw}, 32'h81);
    repeat (C) @(negedge clk);
    snap();
    send_frame_par(8'h07, 1'b1);
    check("par_good_rdy", rdy_cnt - rdy0, 32'd1);
    check("par_good_rxdw", {24'd0, rxdw}, 32'h07);
    check("par_good_no_err", pe_cnt - pe0, 32'd0);
`else
    check("noparity_never_err", pe_cnt, 32'd0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
